cordic_vector_iter: RTL and testbench

//  Iterative CORDIC in vectoring mode. Converts a Cartesian (x,y) sample to magnitude and phase (atan2).

---
 rtl/cordic_vector_iter.sv | 200 ++++++++++++++++++++
 tb/tb_cordic_vector_iter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vector_iter.sv
`default_nettype none
// ============================================================================
// Module   : cordic_vector_iter
// Desc     : Iterative vectoring CORDIC, (x,y) -> magnitude and atan2 phase
//            in degrees x10000. Define CORDIC_MAG_CORR_EN to remove the
//            CORDIC gain from mag_out (otherwise mag_out is raw X).
// Revision : 1.0 - initial release
// ============================================================================
module cordic_vector_iter #(
   parameter int W_IN   = 24,
   parameter int W_INT  = 26,
   parameter int W_PH   = 22,
   parameter int N_ITER = 14
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W_IN-1:0]   x_in,
   input  logic [W_IN-1:0]   y_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W_IN-1:0]   mag_out,
   output logic [W_PH-1:0]   phase_out,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_CORR = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic signed [W_PH-1:0] c_Z_P90  = W_PH'(900000);
   localparam logic signed [W_PH-1:0] c_Z_M90  = W_PH'(-900000);
   localparam logic signed [W_PH-1:0] c_Z_P180 = W_PH'(1800000);
   localparam logic signed [W_PH-1:0] c_Z_M180 = W_PH'(-1800000);
   localparam logic [3:0]             c_LAST   = 4'(N_ITER - 1);

   state_t                  r_state;
   logic signed [W_INT-1:0] r_x;
   logic signed [W_INT-1:0] r_y;
   logic signed [W_PH-1:0]  r_z;
   logic [3:0]              r_iter;
   logic                    r_zero;

   logic signed [W_INT-1:0] w_x_ext;
   logic signed [W_INT-1:0] w_y_ext;
   logic signed [W_INT-1:0] w_fold_x;
   logic signed [W_INT-1:0] w_fold_y;
   logic signed [W_PH-1:0]  w_fold_z;
   logic signed [W_INT-1:0] w_x_sh;
   logic signed [W_INT-1:0] w_y_sh;
   logic signed [W_PH-1:0]  w_angle;
   logic signed [W_INT-1:0] w_x_nxt;
   logic signed [W_INT-1:0] w_y_nxt;
   logic signed [W_PH-1:0]  w_z_nxt;
   logic signed [W_PH-1:0]  w_phase;
   logic [W_IN-1:0]         w_mag;

   assign w_x_ext = {{(W_INT-W_IN){x_in[W_IN-1]}}, x_in};
   assign w_y_ext = {{(W_INT-W_IN){y_in[W_IN-1]}}, y_in};

   // Rotate left-half-plane vectors by +/-90 deg so the iterations converge
   always_comb begin
      w_fold_x = w_x_ext;
      w_fold_y = w_y_ext;
      w_fold_z = '0;
      if (x_in[W_IN-1]) begin
         if (!y_in[W_IN-1]) begin
            w_fold_x = w_y_ext;
            w_fold_y = -w_x_ext;
            w_fold_z = c_Z_P90;
         end else begin
            w_fold_x = -w_y_ext;
            w_fold_y = w_x_ext;
            w_fold_z = c_Z_M90;
         end
      end
   end

   always_comb begin
      w_angle = '0;
      case (r_iter)
         4'd0:    w_angle = W_PH'(450000);
         4'd1:    w_angle = W_PH'(265651);
         4'd2:    w_angle = W_PH'(140362);
         4'd3:    w_angle = W_PH'(71250);
         4'd4:    w_angle = W_PH'(35763);
         4'd5:    w_angle = W_PH'(17899);
         4'd6:    w_angle = W_PH'(8952);
         4'd7:    w_angle = W_PH'(4476);
         4'd8:    w_angle = W_PH'(2238);
         4'd9:    w_angle = W_PH'(1119);
         4'd10:   w_angle = W_PH'(560);
         4'd11:   w_angle = W_PH'(280);
         4'd12:   w_angle = W_PH'(140);
         4'd13:   w_angle = W_PH'(70);
         default: w_angle = '0;
      endcase
   end

   assign w_x_sh = r_x >>> r_iter;
   assign w_y_sh = r_y >>> r_iter;

   // Drive Y toward zero; both updates use the pre-step X and Y
   always_comb begin
      if (!r_y[W_INT-1]) begin
         w_x_nxt = r_x + w_y_sh;
         w_y_nxt = r_y - w_x_sh;
         w_z_nxt = r_z + w_angle;
      end else begin
         w_x_nxt = r_x - w_y_sh;
         w_y_nxt = r_y + w_x_sh;
         w_z_nxt = r_z - w_angle;
      end
   end

   always_comb begin
      if (r_zero) begin
         w_phase = '0;
      end else if (r_z <= c_Z_M180) begin
         w_phase = c_Z_P180;
      end else begin
         w_phase = r_z;
      end
   end

`ifdef CORDIC_MAG_CORR_EN
   localparam int K_GAIN = 16468;
   localparam int W_PROD = 48;

   logic [W_PROD-1:0] w_prod;

   // X is non-negative after the fold, so unsigned division truncates toward 0
   assign w_prod = W_PROD'(unsigned'(r_x)) * W_PROD'(10000);
   assign w_mag  = W_IN'(w_prod / W_PROD'(K_GAIN));
`else
   assign w_mag  = r_x[W_IN-1:0];
`endif

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state   <= S_IDLE;
         r_x       <= '0;
         r_y       <= '0;
         r_z       <= '0;
         r_iter    <= '0;
         r_zero    <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         mag_out   <= '0;
         phase_out <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  r_x      <= w_fold_x;
                  r_y      <= w_fold_y;
                  r_z      <= w_fold_z;
                  r_iter   <= '0;
                  r_zero   <= (x_in == '0) && (y_in == '0);
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  r_state  <= S_ITER;
               end
            end
            S_ITER: begin
               r_x <= w_x_nxt;
               r_y <= w_y_nxt;
               r_z <= w_z_nxt;
               if (r_iter == c_LAST) begin
                  r_state <= S_CORR;
               end else begin
                  r_iter <= r_iter + 4'd1;
               end
            end
            S_CORR: begin
               mag_out   <= r_zero ? '0 : w_mag;
               phase_out <= w_phase;
               out_valid <= 1'b1;
               busy      <= 1'b0;
               r_state   <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cordic_vector_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_vector_iter
// Desc     : Self-checking bench for cordic_vector_iter (vectors, random
//            samples against a real-arithmetic atan2/hypot model, handshakes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_vector_iter;

   localparam real PI = 3.14159265358979;
`ifdef CORDIC_MAG_CORR_EN
   localparam bit  CORR_EN  = 1'b1;
   localparam real GAIN_OUT = 1.0;
`else
   localparam bit  CORR_EN  = 1'b0;
   localparam real GAIN_OUT = 1.6468;
`endif

   logic        clk;
   logic        aresetn;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] x_in;
   logic [23:0] y_in;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] mag_out;
   logic [21:0] phase_out;
   logic        busy;

   int total = 0;
   int bad   = 0;

   cordic_vector_iter dut (
      .clk       (clk),
      .aresetn   (aresetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .y_in      (y_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mag_out   (mag_out),
      .phase_out (phase_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int x;
      int y;
      int ph;
      int ph_tol;
      int mag_c;
      int tol_c;
      int mag_r;
      int tol_r;
   } vec_t;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic real model_mag(input int x, input int y);
      return $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
   endfunction

   function automatic int model_phase(input int x, input int y);
      if (x == 0 && y == 0) return 0;
      return int'($atan2(real'(y), real'(x)) * 1800000.0 / PI);
   endfunction

   task automatic check(input string name, input bit ok, input int act, input int exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model-based result check; phase difference taken modulo 360 deg
   task automatic check_model(input string name, input int x, input int y,
                              input int mag, input int ph);
      real m;
      int  em, et, ep, d;
      m  = model_mag(x, y) * GAIN_OUT;
      em = int'(m);
      et = int'(m * 0.0005) + 8;
      ep = model_phase(x, y);
      d  = ph - ep;
      if (d > 1800000)  d -= 3600000;
      if (d < -1800000) d += 3600000;
      check({name, " mag"},   iabs(mag - em) <= et, mag, em);
      check({name, " phase"}, iabs(d) <= 150, ph, ep);
   endtask

   task automatic convert(input int x, input int y, output int mag, output int ph,
                          output int lat);
      x_in     = 24'(x);
      y_in     = 24'(y);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      mag = int'(mag_out);
      ph  = int'($signed(phase_out));
      @(posedge clk); #1;
   endtask

   vec_t tbl[8];

   initial begin
      int   mag, ph, lat, em, et, cyc_last, nacc, k;
      bit   stable, seen;
      logic [23:0] hold_mag;
      logic [21:0] hold_ph;

      tbl[0] = '{10000,    0,        0,        150, 10000,   7,    16468,   3};
      tbl[1] = '{0,        10000,    900000,   150, 10000,   10,   16468,   16};
      tbl[2] = '{-10000,   0,        1800000,  150, 10000,   10,   16468,   16};
      tbl[3] = '{-10000,   -10000,   -1350000, 150, 14142,   10,   23289,   16};
      tbl[4] = '{10000,    -10000,   -450000,  150, 14142,   10,   23289,   16};
      tbl[5] = '{2000000,  2000000,  450000,   150, 2828427, 1416, 4657854, 2331};
      tbl[6] = '{0,        0,        0,        0,   0,       0,    0,       0};
      tbl[7] = '{1,        -2000000, -900000,  150, 2000000, 1010, 3293600, 1660};

      aresetn   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x_in      = '0;
      y_in      = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst in_ready",  in_ready  === 1'b1, int'(in_ready), 1);
      check("rst out_valid", out_valid === 1'b0, int'(out_valid), 0);
      aresetn = 1'b1;
      @(posedge clk); #1;
      check("post-rst in_ready",  in_ready  === 1'b1, int'(in_ready), 1);
      check("post-rst out_valid", out_valid === 1'b0, int'(out_valid), 0);
      check("post-rst busy",      busy      === 1'b0, int'(busy), 0);
      check("post-rst mag",       mag_out   === 24'd0, int'(mag_out), 0);
      check("post-rst phase",     phase_out === 22'd0, int'(phase_out), 0);

      // Directed vectors
      for (int i = 0; i < 8; i++) begin
         convert(tbl[i].x, tbl[i].y, mag, ph, lat);
         em = CORR_EN ? tbl[i].mag_c : tbl[i].mag_r;
         et = CORR_EN ? tbl[i].tol_c : tbl[i].tol_r;
         check($sformatf("vec%0d latency", i), lat == 15, lat, 15);
         check($sformatf("vec%0d mag", i), iabs(mag - em) <= et, mag, em);
         check($sformatf("vec%0d phase", i), iabs(ph - tbl[i].ph) <= tbl[i].ph_tol,
               ph, tbl[i].ph);
      end

      // Random samples against the model
      for (int n = 0; n < 30; n++) begin
         int xr, yr;
         do begin
            xr = int'($urandom_range(4000000)) - 2000000;
            yr = int'($urandom_range(4000000)) - 2000000;
         end while (model_mag(xr, yr) < 100000.0);
         convert(xr, yr, mag, ph, lat);
         check($sformatf("rand%0d latency", n), lat == 15, lat, 15);
         check_model($sformatf("rand%0d (%0d,%0d)", n, xr, yr), xr, yr, mag, ph);
      end

      // Downstream back-pressure: result must hold while out_ready is low
      out_ready = 1'b0;
      x_in = 24'(30000); y_in = 24'(40000); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("hold latency", lat == 15, lat, 15);
      hold_mag = mag_out;
      hold_ph  = phase_out;
      stable   = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (mag_out !== hold_mag || phase_out !== hold_ph || out_valid !== 1'b1 ||
             in_ready !== 1'b0)
            stable = 1'b0;
      end
      check("hold stable", stable, int'(stable), 1);
      check_model("hold", 30000, 40000, int'(hold_mag), int'($signed(hold_ph)));
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release out_valid", out_valid === 1'b0, int'(out_valid), 0);
      check("release in_ready",  in_ready  === 1'b1, int'(in_ready), 1);

      // New data offered mid-conversion must be ignored
      x_in = 24'(10000); y_in = 24'(0); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("iter busy",     busy     === 1'b1, int'(busy), 1);
      check("iter in_ready", in_ready === 1'b0, int'(in_ready), 0);
      x_in = 24'(-10000); y_in = 24'(-10000); in_valid = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      in_valid = 1'b0; x_in = '0; y_in = '0;
      lat = 5;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("ignore latency", lat == 15, lat, 15);
      check_model("ignore", 10000, 0, int'(mag_out), int'($signed(phase_out)));
      @(posedge clk); #1;

      // Back-to-back acceptance period
      x_in = 24'(20000); y_in = 24'(-5000); in_valid = 1'b1;
      cyc_last = -1;
      nacc     = 0;
      for (int c = 0; c < 80 && nacc < 4; c++) begin
         if (in_ready) begin
            if (cyc_last >= 0)
               check("b2b interval", (c - cyc_last) == 17, c - cyc_last, 17);
            cyc_last = c;
            nacc++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("b2b accepts", nacc == 4, nacc, 4);
      k = 0;
      while (!out_valid && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      check_model("b2b last", 20000, -5000, int'(mag_out), int'($signed(phase_out)));
      @(posedge clk); #1;

      // Reset during iteration 7 aborts the sample
      x_in = 24'(10000); y_in = 24'(0); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) begin @(posedge clk); #1; end
      aresetn = 1'b0;
      #1;
      check("abort busy",     busy     === 1'b0, int'(busy), 0);
      check("abort in_ready", in_ready === 1'b1, int'(in_ready), 1);
      repeat (2) @(posedge clk);
      #1;
      aresetn = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("abort no output", !seen, int'(seen), 0);
      convert(10000, -10000, mag, ph, lat);
      check("after abort latency", lat == 15, lat, 15);
      check_model("after abort", 10000, -10000, mag, ph);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
